// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall, flush and forwarding controller for the RISC-V pipeline.
// A per-position scoreboard of in-flight writers drives ID stalls and EX forwarding.
module pipe_hazard_ctrl #(
    parameter int NUM_REGS   = 32,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int MC_MAX     = 34,
    localparam int AW = $clog2(NUM_REGS),
    localparam int LW = $clog2(MC_MAX + 1),
    localparam int FW = $clog2(FWD_STAGES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid_i,
    input  logic [AW-1:0] id_rs1_i,
    input  logic [AW-1:0] id_rs2_i,
    input  logic          id_use_rs1_i,
    input  logic          id_use_rs2_i,
    input  logic [AW-1:0] id_rd_i,
    input  logic          id_we_i,
    input  logic          id_load_i,
    input  logic          id_early_i,
    input  logic          id_mc_i,
    input  logic [LW-1:0] id_mc_lat_i,
    input  logic          br_taken_i,
    output logic          stall_o,
    output logic          bubble_o,
    output logic          ex_hold_o,
    output logic          flush_o,
    output logic [FW-1:0] fwd_a_o,
    output logic [FW-1:0] fwd_b_o
);

    logic          r_vld [0:FWD_STAGES];
    logic          r_we  [0:FWD_STAGES];
    logic          r_ld  [0:FWD_STAGES];
    logic [AW-1:0] r_rd  [0:FWD_STAGES];
    logic [AW-1:0] r_rs1_p0;
    logic [AW-1:0] r_rs2_p0;
    logic          r_use1_p0;
    logic          r_use2_p0;
    logic [LW-1:0] r_mc_cnt;

    logic          w_mc_busy;
    logic          w_load_use;
    logic          w_early;
    logic          w_new_vld;
    logic          w_mc_start;

    function automatic logic f_match(input logic vld, input logic we,
                                     input logic [AW-1:0] rd,
                                     input logic [AW-1:0] src, input logic use_src);
        return vld & we & (rd != '0) & (rd == src) & use_src;
    endfunction

    assign w_mc_busy = (r_mc_cnt != '0);

    // Positions at or beyond FWD_STAGES are covered by the register file.
    always_comb begin
        w_load_use = 1'b0;
        w_early    = 1'b0;
        if (id_valid_i) begin
            for (int p = 0; p < FWD_STAGES; p++) begin
                if (f_match(r_vld[p], r_we[p], r_rd[p], id_rs1_i, id_use_rs1_i) ||
                    f_match(r_vld[p], r_we[p], r_rd[p], id_rs2_i, id_use_rs2_i)) begin
                    if (p < LOAD_LAT && r_ld[p])
                        w_load_use = 1'b1;
                    if (id_early_i)
                        w_early = 1'b1;
                end
            end
        end
    end

    assign stall_o    = w_mc_busy | w_load_use | w_early;
    assign bubble_o   = (w_load_use | w_early) & ~w_mc_busy;
    assign ex_hold_o  = w_mc_busy;
    assign flush_o    = br_taken_i & id_valid_i & ~stall_o;
    assign w_new_vld  = id_valid_i & ~bubble_o;
    assign w_mc_start = w_new_vld & id_mc_i & (id_mc_lat_i >= LW'(2));

    // Scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
        fwd_a_o = '0;
        fwd_b_o = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (f_match(r_vld[k], r_we[k], r_rd[k], r_rs1_p0, r_use1_p0))
                fwd_a_o = FW'(k);
            if (f_match(r_vld[k], r_we[k], r_rd[k], r_rs2_p0, r_use2_p0))
                fwd_b_o = FW'(k);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= FWD_STAGES; k++)
                r_vld[k] <= 1'b0;
            r_mc_cnt <= '0;
        end else begin
            for (int k = 2; k <= FWD_STAGES; k++)
                r_vld[k] <= r_vld[k-1];
            if (w_mc_busy) begin
                r_vld[1] <= 1'b0;
                r_mc_cnt <= r_mc_cnt - LW'(1);
            end else begin
                r_vld[1] <= r_vld[0];
                r_vld[0] <= w_new_vld;
                if (w_mc_start)
                    r_mc_cnt <= id_mc_lat_i - LW'(1);
            end
        end
    end

    // Entry payload needs no reset; every use is qualified by its valid bit.
    always_ff @(posedge clk) begin
        for (int k = 2; k <= FWD_STAGES; k++) begin
            r_we[k] <= r_we[k-1];
            r_ld[k] <= r_ld[k-1];
            r_rd[k] <= r_rd[k-1];
        end
        if (!w_mc_busy) begin
            r_we[1]   <= r_we[0];
            r_ld[1]   <= r_ld[0];
            r_rd[1]   <= r_rd[0];
            r_we[0]   <= id_we_i;
            r_ld[0]   <= id_load_i;
            r_rd[0]   <= id_rd_i;
            r_rs1_p0  <= id_rs1_i;
            r_rs2_p0  <= id_rs2_i;
            r_use1_p0 <= id_use_rs1_i;
            r_use2_p0 <= id_use_rs2_i;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default parameters on dut,
// FWD_STAGES=3 / LOAD_LAT=2 on dut2 sharing the same ID inputs.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use1, id_use2, id_we, id_load, id_early, id_mc;
    logic [5:0] id_lat;
    logic       br_taken;

    logic       stall, bubble, hold, flush;
    logic [1:0] fwd_a, fwd_b;
    logic       stall2, bubble2, hold2, flush2;
    logic [1:0] fwd_a2, fwd_b2;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use1), .id_use_rs2_i(id_use2),
        .id_rd_i(id_rd), .id_we_i(id_we), .id_load_i(id_load),
        .id_early_i(id_early), .id_mc_i(id_mc), .id_mc_lat_i(id_lat),
        .br_taken_i(br_taken), .stall_o(stall), .bubble_o(bubble),
        .ex_hold_o(hold), .flush_o(flush), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b)
    );

    pipe_hazard_ctrl #(.FWD_STAGES(3), .LOAD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid_i(id_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use1), .id_use_rs2_i(id_use2),
        .id_rd_i(id_rd), .id_we_i(id_we), .id_load_i(id_load),
        .id_early_i(id_early), .id_mc_i(id_mc), .id_mc_lat_i(id_lat),
        .br_taken_i(br_taken), .stall_o(stall2), .bubble_o(bubble2),
        .ex_hold_o(hold2), .flush_o(flush2), .fwd_a_o(fwd_a2), .fwd_b_o(fwd_b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic we, input logic ld, input logic early,
                          input logic mc, input logic [5:0] lat);
        id_valid = v;  id_rs1 = rs1;  id_rs2 = rs2;  id_use1 = u1;  id_use2 = u2;
        id_rd = rd;    id_we = we;    id_load = ld;  id_early = early;
        id_mc = mc;    id_lat = lat;
    endtask

    task automatic set_nop;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        br_taken = 1'b0;
        set_nop();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        br_taken = 1'b0;
        set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
        #2;
        checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL reset_stall got %0b exp 0", stall); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %0b exp 0", bubble); end
        checks++; if (hold !== 1'b0)   begin errors++; $display("FAIL reset_hold got %0b exp 0", hold); end
        checks++; if (flush !== 1'b0)  begin errors++; $display("FAIL reset_flush got %0b exp 0", flush); end
        checks++; if (fwd_a !== 2'd0)  begin errors++; $display("FAIL reset_fwd_a got %0d exp 0", fwd_a); end
        checks++; if (fwd_b !== 2'd0)  begin errors++; $display("FAIL reset_fwd_b got %0d exp 0", fwd_b); end
        do_reset();
    endtask

    task automatic test_load_use;
        do_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);   // lw x5
        tick();
        set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);   // add x6,x5,x1
        #2;
        checks++; if (stall !== 1'b1)  begin errors++; $display("FAIL lu_stall got %0b exp 1", stall); end
        checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble got %0b exp 1", bubble); end
        tick();
        #2;
        checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL lu_stall2 got %0b exp 0", stall); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL lu_bubble2 got %0b exp 0", bubble); end
        tick();
        set_nop();
        #2;
        checks++; if (fwd_a !== 2'd2) begin errors++; $display("FAIL lu_fwd_a got %0d exp 2", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL lu_fwd_b got %0d exp 0", fwd_b); end
        // A load to x0 never creates a hazard.
        do_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_x0_stall got %0b exp 0", stall); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);   // add x5
        tick();
        set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);   // sub x7,x5,x5
        #2;
        checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL b2b_stall got %0b exp 0", stall); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL b2b_bubble got %0b exp 0", bubble); end
        tick();
        set_nop();
        #2;
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL b2b_fwd_a got %0d exp 1", fwd_a); end
        checks++; if (fwd_b !== 2'd1) begin errors++; $display("FAIL b2b_fwd_b got %0d exp 1", fwd_b); end
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);   // add x0
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_x0_stall got %0b exp 0", stall); end
        tick();
        set_nop();
        #2;
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL b2b_x0_fwd_a got %0d exp 0", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL b2b_x0_fwd_b got %0d exp 0", fwd_b); end
    endtask

    task automatic test_youngest;
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        tick();
        tick();
        set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);   // uses rs1 only
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL young_stall got %0b exp 0", stall); end
        tick();
        set_nop();
        #2;
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL young_fwd_a got %0d exp 1", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL young_fwd_b_unused got %0d exp 0", fwd_b); end
    endtask

    task automatic test_early_branch;
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);   // add x5
        tick();
        set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);   // beq x5,x0
        br_taken = 1'b1;
        #2;
        checks++; if (stall !== 1'b1)  begin errors++; $display("FAIL early_stall1 got %0b exp 1", stall); end
        checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL early_bubble1 got %0b exp 1", bubble); end
        checks++; if (flush !== 1'b0)  begin errors++; $display("FAIL early_flush1 got %0b exp 0", flush); end
        tick();
        #2;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL early_stall2 got %0b exp 1", stall); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL early_flush2 got %0b exp 0", flush); end
        tick();
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL early_stall3 got %0b exp 0", stall); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL early_flush3 got %0b exp 1", flush); end
        tick();
        set_nop();
        #2;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_novalid got %0b exp 0", flush); end
        br_taken = 1'b0;
    endtask

    task automatic test_multicycle;
        int  n;
        bit  done;
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 6'd34);  // div x10
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mc_issue_stall got %0b exp 0", stall); end
        tick();
        set_id(1'b1, 5'd10, 5'd3, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            #2;
            if (hold === 1'b1) begin
                checks++;
                if (stall !== 1'b1 || bubble !== 1'b0) begin
                    errors++;
                    $display("FAIL mc_hold_cycle%0d got stall %0b bubble %0b exp stall 1 bubble 0", i, stall, bubble);
                end
                n++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        checks++; if (n != 33)        begin errors++; $display("FAIL mc_hold_len got %0d exp 33", n); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mc_release_stall got %0b exp 0", stall); end
        tick();
        set_nop();
        #2;
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL mc_fwd_a got %0d exp 1", fwd_a); end
        // Latency 2 holds one cycle; 1 and 0 behave as single-cycle.
        do_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 6'd2);
        tick();
        set_nop();
        #2;
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL mc_lat2_hold got %0b exp 1", hold); end
        tick();
        #2;
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL mc_lat2_release got %0b exp 0", hold); end
        for (int l = 0; l < 2; l++) begin
            do_reset();
            set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 6'(l));
            tick();
            set_nop();
            #2;
            checks++; if (hold !== 1'b0) begin errors++; $display("FAIL mc_lat%0d_hold got %0b exp 0", l, hold); end
        end
    endtask

    task automatic test_reset_mid_mc;
        do_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 6'd34);
        tick();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        repeat (10) tick();
        #1;
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL rstmid_pre_hold got %0b exp 1", hold); end
        rst = 1'b1;
        #1;
        checks++; if (hold !== 1'b0)   begin errors++; $display("FAIL rstmid_hold got %0b exp 0", hold); end
        checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL rstmid_stall got %0b exp 0", stall); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL rstmid_bubble got %0b exp 0", bubble); end
        checks++; if (flush !== 1'b0)  begin errors++; $display("FAIL rstmid_flush got %0b exp 0", flush); end
        checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
            errors++; $display("FAIL rstmid_fwd got %0d/%0d exp 0/0", fwd_a, fwd_b);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_fwd3;
        do_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);   // lw x5
        tick();
        set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);   // add x6,x5
        #2;
        checks++; if (stall2 !== 1'b1 || bubble2 !== 1'b1) begin
            errors++; $display("FAIL f3_cycle1 got stall %0b bubble %0b exp 1 1", stall2, bubble2);
        end
        tick();
        #2;
        checks++; if (stall2 !== 1'b1) begin errors++; $display("FAIL f3_cycle2_stall got %0b exp 1", stall2); end
        tick();
        #2;
        checks++; if (stall2 !== 1'b0) begin errors++; $display("FAIL f3_cycle3_stall got %0b exp 0", stall2); end
        tick();
        set_nop();
        #2;
        checks++; if (fwd_a2 !== 2'd3) begin errors++; $display("FAIL f3_fwd_a got %0d exp 3", fwd_a2); end
        // A pending load-use under a multi-cycle hold must not bubble.
        do_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);   // lw x5
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 6'd3);   // div x9, lat 3
        #2;
        checks++; if (stall2 !== 1'b0) begin errors++; $display("FAIL f3_div_issue_stall got %0b exp 0", stall2); end
        tick();
        set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);   // add x6,x5
        #2;
        checks++; if (stall2 !== 1'b1 || hold2 !== 1'b1 || bubble2 !== 1'b0) begin
            errors++; $display("FAIL f3_mc_dominates got stall %0b hold %0b bubble %0b exp 1 1 0", stall2, hold2, bubble2);
        end
    endtask

    initial begin
        rst = 1'b1;
        br_taken = 1'b0;
        set_nop();
        test_reset();
        test_load_use();
        test_back_to_back();
        test_youngest();
        test_early_branch();
        test_multicycle();
        test_reset_mid_mc();
        test_fwd3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, stall, flush and forwarding controller for the RISC-V pipeline. It replaces the fixed 1-cycle load-use detector and 2-stage forwarding unit with a scoreboard that covers:
- a configurable number of forwarding stages;
- configurable load data latency;
- operands consumed early in ID (branch compare);
- multi-cycle execute operations (mul/div) that hold EX for a per-instruction latency.

It sits beside the ID stage and drives the PC/IF_ID hold, the ID_EX bubble, the IF_ID flush and the EX operand forwarding muxes.

## Interface
- NUM_REGS, 32, architectural register count; AW = clog2(NUM_REGS)
- FWD_STAGES, 2, pipeline registers after ID_EX that can forward into EX (1 = EX_MEM, 2 = MEM_WB, …); ≥ 1
- LOAD_LAT, 1, extra stages before load data is forwardable; must be < FWD_STAGES
- MC_MAX, 34, maximum multi-cycle op latency; LW = clog2(MC_MAX+1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i / id_rs2_i  in  AW  ID source registers
- id_use_rs1_i / id_use_rs2_i  in  1  source actually read
- id_rd_i  in  AW  ID destination
- id_we_i  in  1  ID writes rd
- id_load_i  in  1  ID is a load
- id_early_i  in  1  ID consumes operands in ID (branch compare)
- id_mc_i  in  1  ID is a multi-cycle op
- id_mc_lat_i  in  LW  its latency in cycles, 1..MC_MAX
- br_taken_i  in  1  branch/jump redirect resolved in ID
- stall_o  out  1  hold PC and IF_ID
- bubble_o  out  1  load NOP into ID_EX
- ex_hold_o  out  1  hold ID_EX (multi-cycle busy)
- flush_o  out  1  clear IF_ID
- fwd_a_o / fwd_b_o  out  clog2(FWD_STAGES+1)  EX operand select: 0 = ID_EX data; k = pipeline register k

## Operation
Scoreboard:
- Positions 0..FWD_STAGES; position 0 = ID_EX, k = k-th register after it.
- Each entry holds {valid, rd, we, load}.
- Position 0 also holds rs1, rs2, use1, use2 of the instruction in EX.
- A "match" requires valid & we & rd ≠ 0 & rd = source & use flag set. x0 never matches.

Hazards, evaluated only when id_valid_i:
- load_use: a matching load entry at position p < LOAD_LAT.
- early: id_early_i and any matching entry at position p < FWD_STAGES (the register file covers older writers).
- mc_busy: the multi-cycle counter is non-zero.

Outputs:
- stall_o = mc_busy | load_use | early.
- bubble_o = (load_use | early) & ~mc_busy.
- ex_hold_o = mc_busy.
- flush_o = br_taken_i & id_valid_i & ~stall_o. A redirect during a stall is ignored; upstream re-presents it.

Scoreboard update each cycle:
- If mc_busy: position 0 holds, position 1 loads invalid, positions ≥2 shift, counter decrements.
- Else: all entries shift up one position; entry FWD_STAGES drops.
  - Position 0 loads the ID fields with valid = id_valid_i & ~bubble_o.
  - If the loaded entry has id_mc_i and id_mc_lat_i ≥ 2, the counter loads id_mc_lat_i − 1.

Forwarding (combinational from flops):
- fwd_a_o = smallest k in 1..FWD_STAGES whose entry matches position 0 rs1/use1; 0 if none. fwd_b_o is the same for rs2.
- The youngest writer wins.

## Timing
- Reset: all entries invalid, counter 0. stall_o = bubble_o = ex_hold_o = flush_o = 0, fwd_a_o = fwd_b_o = 0.
- All outputs are combinational from flops and ID inputs. No added latency; they are valid within the same cycle.
- Load-use penalty is exactly LOAD_LAT − p cycles for a producer at position p.
- A multi-cycle op with latency L holds EX for L − 1 cycles and inserts L − 1 bubbles at position 1.
- id_mc_lat_i = 0 or 1 behaves as a single-cycle op.
- With simultaneous load_use and mc_busy, mc_busy dominates: hold, no bubble. load_use is re-evaluated after release.
- rst asserted mid multi-cycle op clears the counter and scoreboard immediately (asynchronous).

## Test plan
- Default params. `lw x5` in EX, `add x6,x5,x1` in ID → stall_o = 1 and bubble_o = 1 for exactly 1 cycle. Next cycle the add is in EX with fwd_a_o = 2.
- `add x5` then `sub x7,x5,x5` back-to-back → no stall; fwd_a_o = fwd_b_o = 1. Same with rd = x0 → fwd 0, no stall.
- x5 written at positions 1 and 2 → fwd_a_o = 1 (youngest wins).
- `beq x5,x0` in ID with `add x5` at position 0 → stall 2 cycles. Then br_taken_i = 1 → flush_o = 1 for 1 cycle.
- `div` with id_mc_lat_i = 34 → ex_hold_o = stall_o = 1 for 33 cycles, bubble_o = 0, 33 invalid entries at position 1. rst pulse at hold cycle 10 → all outputs 0 the same cycle.
- FWD_STAGES = 3, LOAD_LAT = 2: load at position 0 with dependent in ID → 2-cycle stall, then fwd_a_o = 3.
